// File: rtl/fpu_pkg.sv
// Shared IEEE-754 single-precision constants and type definitions for the FPU blocks.
package fpu_pkg;

  localparam int unsigned FP_BIAS  = 127;
  localparam int unsigned FP_EXP_W = 8;
  localparam int unsigned FP_MAN_W = 23;

  localparam logic [31:0] INT_MAX = 32'h7FFF_FFFF;
  localparam logic [31:0] INT_MIN = 32'h8000_0000;

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  typedef enum logic [1:0] {ClsZero, ClsNormal, ClsInf, ClsNan} fp_class_e;

endpackage

// File: rtl/fpu_unpack.sv
// Combinational single-precision unpacker: sign, unbiased exponent, mantissa with hidden bit
// and operand class. Zero and denormals are both reported as ClsZero.
module fpu_unpack
  import fpu_pkg::*;
(
  input  logic                  fpu_i,
  input  logic [30:0]           bits_i,
  output logic                  sign_o,
  output logic signed [8:0]     exp_o,
  output logic [FP_MAN_W:0]     man_o,
  output fp_class_e             cls_o
);

  logic [FP_EXP_W-1:0] biased;
  logic                frac_nz;

  assign sign_o  = fpu_i;
  assign biased  = bits_i[30:23];
  assign frac_nz = |bits_i[22:0];
  assign exp_o   = $signed({1'b0, biased} - 9'(FP_BIAS));
  assign man_o   = {1'b1, bits_i[22:0]};

  always_comb begin
    cls_o = ClsNormal;
    if (biased == '0) begin
      cls_o = ClsZero;
    end else if (biased == '1) begin
      cls_o = frac_nz ? ClsNan : ClsInf;
    end
  end

endmodule

// File: rtl/fpu_to_decimal.sv
// Iterative float-to-int32 converter, one alignment bit per clock, valid/ready on both sides.
// Define FPU_TO_DEC_ROUND_NEAREST_EN for round-to-nearest-even; default truncates toward zero.
module fpu_to_decimal
  import fpu_pkg::*;
#(
  parameter int unsigned MAX_SHIFT = 24
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_fpu,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_dec,
  output logic        out_overflow,
  output logic        out_inexact
);

  localparam int unsigned CntW = $clog2(MAX_SHIFT + 1);

`ifdef FPU_TO_DEC_ROUND_NEAREST_EN
  localparam logic signed [8:0] MinExp = -9'sd1;
`else
  localparam logic signed [8:0] MinExp = 9'sd0;
`endif

  state_e            state_q;
  logic [31:0]       acc_q;
  logic [CntW-1:0]   cnt_q;
  logic              dir_left_q;
  logic              sign_q;
  logic              sticky_q;
  logic [31:0]       out_dec_q;
  logic              out_valid_q;
  logic              out_overflow_q;
  logic              out_inexact_q;

  logic              u_sign;
  logic signed [8:0] u_exp;
  logic [FP_MAN_W:0] u_man;
  fp_class_e         u_cls;

  logic [31:0]       acc_rnd;
  logic              inexact_c;

  fpu_unpack u_unpack (
    .fpu_i  (in_fpu[31]),
    .bits_i (in_fpu[30:0]),
    .sign_o (u_sign),
    .exp_o  (u_exp),
    .man_o  (u_man),
    .cls_o  (u_cls)
  );

`ifdef FPU_TO_DEC_ROUND_NEAREST_EN
  logic guard_q;

  always_comb begin
    acc_rnd   = acc_q + {31'b0, guard_q & (sticky_q | acc_q[0])};
    inexact_c = guard_q | sticky_q;
  end
`else
  always_comb begin
    acc_rnd   = acc_q;
    inexact_c = sticky_q;
  end
`endif

  assign in_ready     = (state_q == StIdle) && !rst;
  assign out_valid    = out_valid_q;
  assign out_dec      = out_dec_q;
  assign out_overflow = out_overflow_q;
  assign out_inexact  = out_inexact_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= StIdle;
      acc_q          <= '0;
      cnt_q          <= '0;
      dir_left_q     <= 1'b0;
      sign_q         <= 1'b0;
      sticky_q       <= 1'b0;
`ifdef FPU_TO_DEC_ROUND_NEAREST_EN
      guard_q        <= 1'b0;
`endif
      out_dec_q      <= '0;
      out_valid_q    <= 1'b0;
      out_overflow_q <= 1'b0;
      out_inexact_q  <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (in_valid) begin
            sign_q         <= u_sign;
            acc_q          <= {8'b0, u_man};
            sticky_q       <= 1'b0;
`ifdef FPU_TO_DEC_ROUND_NEAREST_EN
            guard_q        <= 1'b0;
`endif
            out_dec_q      <= '0;
            out_overflow_q <= 1'b0;
            out_inexact_q  <= 1'b0;
            state_q        <= StDone;
            out_valid_q    <= 1'b1;
            unique case (u_cls)
              ClsZero: out_inexact_q <= |in_fpu[22:0];
              ClsNan:  out_overflow_q <= 1'b1;
              ClsInf: begin
                out_dec_q      <= u_sign ? INT_MIN : INT_MAX;
                out_overflow_q <= 1'b1;
              end
              default: begin
                if (u_exp >= 9'sd31) begin
                  // -2^31 is the only representable value with e >= 31.
                  out_dec_q      <= u_sign ? INT_MIN : INT_MAX;
                  out_overflow_q <= (in_fpu != 32'hCF00_0000);
                end else if (u_exp < MinExp) begin
                  out_inexact_q <= 1'b1;
                end else begin
                  dir_left_q  <= (u_exp > 9'sd23);
                  cnt_q       <= (u_exp > 9'sd23) ? CntW'(u_exp - 9'sd23) : CntW'(9'sd23 - u_exp);
                  state_q     <= StShift;
                  out_valid_q <= 1'b0;
                end
              end
            endcase
          end
        end
        StShift: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - CntW'(1);
            if (dir_left_q) begin
              acc_q <= acc_q << 1;
            end else begin
              acc_q <= acc_q >> 1;
`ifdef FPU_TO_DEC_ROUND_NEAREST_EN
              guard_q  <= acc_q[0];
              sticky_q <= sticky_q | guard_q;
`else
              sticky_q <= sticky_q | acc_q[0];
`endif
            end
          end else begin
            out_dec_q      <= sign_q ? -acc_rnd : acc_rnd;
            out_inexact_q  <= inexact_c;
            out_overflow_q <= 1'b0;
            out_valid_q    <= 1'b1;
            state_q        <= StDone;
          end
        end
        StDone: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
